pingpong_frame_ctrl: RTL and testbench

- Double-buffer (ping-pong) controller for the two frame buffers Buf0/Buf1.
- The host/pixel source fills one buffer while the display scan-out drains the other.
- Swaps buffers on frame boundaries and generates the per-buffer RE/WE/Addr/WData strobes.
- Steers the display-side read-data select.
- Reports frame-done and underrun status to the timing generator.

---
 rtl/pingpong_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_pingpong_frame_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_ctrl.sv
// Ping-pong frame buffer controller: host fills one buffer while the display drains
// the other, swapping on frame boundaries and issuing per-buffer RE/WE/Addr/WData.
module pingpong_frame_ctrl #(
   parameter int DEPTH = 10000,
   parameter int AW    = 20,
   parameter int CW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_valid,
   input  logic [31:0]   wr_data,
   output logic          wr_ready,
   input  logic          rd_req,
   output logic          pix_valid,
   output logic          rd_sel,
   output logic          WE0,
   output logic          RE0,
   output logic [AW-1:0] Addr0,
   output logic          WE1,
   output logic          RE1,
   output logic [AW-1:0] Addr1,
   output logic [31:0]   WData,
   output logic          frame_done,
   output logic          underrun,
   output logic [CW-1:0] frame_cnt,
   output logic [CW-1:0] underrun_cnt
);

   logic          wr_buf_reg;
   logic          rd_buf_reg;
   logic [1:0]    full_reg;
   logic [1:0]    full_next;
   logic [AW-1:0] wr_addr_reg;
   logic [AW-1:0] rd_addr_reg;
   logic [31:0]   wdata_reg;
   logic          pix_valid_reg;
   logic          rd_sel_reg;
   logic          frame_done_reg;
   logic          underrun_reg;
   logic [CW-1:0] frame_cnt_reg;
   logic [CW-1:0] underrun_cnt_reg;

   logic wr_acc;
   logic rd_acc;
   logic rd_miss;
   logic wr_last;
   logic rd_last;

   assign wr_ready = !full_reg[wr_buf_reg];
   assign wr_acc   = wr_valid && wr_ready;
   assign rd_acc   = rd_req && full_reg[rd_buf_reg];
   assign rd_miss  = rd_req && !full_reg[rd_buf_reg];
   assign wr_last  = (wr_addr_reg == AW'(DEPTH - 1));
   assign rd_last  = (rd_addr_reg == AW'(DEPTH - 1));

   // The filling buffer is never full and the draining one always is, so the
   // set and the clear below can never target the same bit.
   always_comb begin
      full_next = full_reg;
      if (wr_acc && wr_last)
         full_next[wr_buf_reg] = 1'b1;
      if (rd_acc && rd_last)
         full_next[rd_buf_reg] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_buf_reg       <= 1'b0;
         rd_buf_reg       <= 1'b0;
         full_reg         <= 2'b00;
         wr_addr_reg      <= '0;
         rd_addr_reg      <= '0;
         wdata_reg        <= '0;
         pix_valid_reg    <= 1'b0;
         rd_sel_reg       <= 1'b0;
         frame_done_reg   <= 1'b0;
         underrun_reg     <= 1'b0;
         frame_cnt_reg    <= '0;
         underrun_cnt_reg <= '0;
      end else begin
         full_reg <= full_next;

         if (wr_acc) begin
            wdata_reg <= wr_data;
            if (wr_last) begin
               wr_addr_reg <= '0;
               wr_buf_reg  <= ~wr_buf_reg;
            end else begin
               wr_addr_reg <= wr_addr_reg + AW'(1);
            end
         end

         if (rd_acc) begin
            rd_sel_reg <= rd_buf_reg;
            if (rd_last) begin
               rd_addr_reg <= '0;
               rd_buf_reg  <= ~rd_buf_reg;
            end else begin
               rd_addr_reg <= rd_addr_reg + AW'(1);
            end
         end

         // Buffer read data lands one cycle after its RE strobe.
         pix_valid_reg  <= RE0 | RE1;
         frame_done_reg <= rd_acc && rd_last;
         underrun_reg   <= rd_miss;

         if (rd_acc && rd_last)
            frame_cnt_reg <= frame_cnt_reg + CW'(1);
         if (rd_miss && (underrun_cnt_reg != {CW{1'b1}}))
            underrun_cnt_reg <= underrun_cnt_reg + CW'(1);
      end
   end

   // Per-buffer strobes and address mux; only one side ever targets a buffer.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_buf
         logic          we_reg;
         logic          re_reg;
         logic [AW-1:0] addr_reg;
         logic          wr_hit;
         logic          rd_hit;

         assign wr_hit = wr_acc && (wr_buf_reg == 1'(gi));
         assign rd_hit = rd_acc && (rd_buf_reg == 1'(gi));

         always_ff @(posedge clk) begin
            if (reset) begin
               we_reg   <= 1'b0;
               re_reg   <= 1'b0;
               addr_reg <= '0;
            end else begin
               we_reg <= wr_hit;
               re_reg <= rd_hit;
               if (wr_hit)
                  addr_reg <= wr_addr_reg;
               else if (rd_hit)
                  addr_reg <= rd_addr_reg;
            end
         end
      end
   endgenerate

   assign WE0          = g_buf[0].we_reg;
   assign RE0          = g_buf[0].re_reg;
   assign Addr0        = g_buf[0].addr_reg;
   assign WE1          = g_buf[1].we_reg;
   assign RE1          = g_buf[1].re_reg;
   assign Addr1        = g_buf[1].addr_reg;
   assign WData        = wdata_reg;
   assign pix_valid    = pix_valid_reg;
   assign rd_sel       = rd_sel_reg;
   assign frame_done   = frame_done_reg;
   assign underrun     = underrun_reg;
   assign frame_cnt    = frame_cnt_reg;
   assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_pingpong_frame_ctrl.sv
// Directed bench for pingpong_frame_ctrl with a 4-pixel frame and 2-bit counters.
module tb_pingpong_frame_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        rd_req;
   logic        pix_valid;
   logic        rd_sel;
   logic        WE0, RE0, WE1, RE1;
   logic [2:0]  Addr0, Addr1;
   logic [31:0] WData;
   logic        frame_done;
   logic        underrun;
   logic [1:0]  frame_cnt;
   logic [1:0]  underrun_cnt;

   int checks   = 0;
   int failures = 0;

   pingpong_frame_ctrl #(.DEPTH(4), .AW(3), .CW(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .rd_req       (rd_req),
      .pix_valid    (pix_valid),
      .rd_sel       (rd_sel),
      .WE0          (WE0),
      .RE0          (RE0),
      .Addr0        (Addr0),
      .WE1          (WE1),
      .RE1          (RE1),
      .Addr1        (Addr1),
      .WData        (WData),
      .frame_done   (frame_done),
      .underrun     (underrun),
      .frame_cnt    (frame_cnt),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Advance one cycle; outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; wr_data = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int fd_seen;
      int b;
      int wb;
      logic [31:0] d;

      do_reset();
      check("rst_WE0", WE0, 0);
      check("rst_RE1", RE1, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_full", dut.full_reg, 0);
      $display("reset done");

      // Fill Buf0 with 0x11..0x44; the top byte must pass through unchanged.
      for (int i = 0; i < 4; i++) begin
         d = 32'hA5000000 | (32'h11 * (i + 1));
         wr_valid = 1'b1; wr_data = d;
         step();
         $display("write buf0 addr=%0d data=%h WE0=%0b Addr0=%0d WData=%h", i, d, WE0, Addr0, WData);
         check("w0_WE0", WE0, 1);
         check("w0_WE1", WE1, 0);
         check("w0_Addr0", Addr0, i);
         check("w0_WData", WData, d);
      end
      check("w0_full", dut.full_reg, 2'b01);
      check("w0_wr_buf", dut.wr_buf_reg, 1);
      check("w0_wr_ready", wr_ready, 1);

      // Fill Buf1; after the 8th accept both are full.
      for (int i = 0; i < 4; i++) begin
         d = 32'h55 * (i + 1);
         wr_data = d;
         step();
         $display("write buf1 addr=%0d data=%h WE1=%0b Addr1=%0d", i, d, WE1, Addr1);
         check("w1_WE1", WE1, 1);
         check("w1_WE0", WE0, 0);
         check("w1_Addr1", Addr1, i);
      end
      check("full_wr_ready", wr_ready, 0);
      check("full_full", dut.full_reg, 2'b11);
      wr_data = 32'h99;
      step();
      $display("9th write held WE0=%0b WE1=%0b", WE0, WE1);
      check("held_WE0", WE0, 0);
      check("held_WE1", WE1, 0);
      check("held_WData", WData, 32'h55 * 4);

      // Drain Buf0 with rd_req held 4 cycles.
      wr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd_req = 1'b1;
         step();
         $display("read buf0 addr=%0d RE0=%0b Addr0=%0d pix_valid=%0b frame_done=%0b", i, RE0, Addr0, pix_valid, frame_done);
         check("r0_RE0", RE0, 1);
         check("r0_RE1", RE1, 0);
         check("r0_Addr0", Addr0, i);
         check("r0_rd_sel", rd_sel, 0);
         check("r0_pix_valid", pix_valid, (i >= 1) ? 1 : 0);
         check("r0_frame_done", frame_done, (i == 3) ? 1 : 0);
      end
      rd_req = 1'b0;
      step();
      check("r0_tail_pix_valid", pix_valid, 1);
      check("r0_tail_RE0", RE0, 0);
      check("r0_tail_frame_done", frame_done, 0);
      check("r0_frame_cnt", frame_cnt, 1);
      check("r0_full", dut.full_reg, 2'b10);
      check("r0_rd_buf", dut.rd_buf_reg, 1);
      check("r0_wr_ready", wr_ready, 1);

      // Underrun from reset: counter saturates at 3.
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         rd_req = 1'b1;
         step();
         $display("underrun cycle=%0d underrun=%0b cnt=%0d", k, underrun, underrun_cnt);
         check("ur_pulse", underrun, 1);
         check("ur_cnt", underrun_cnt, (k > 3) ? 3 : k);
         check("ur_RE", {RE1, RE0}, 0);
         check("ur_pix_valid", pix_valid, 0);
      end
      rd_req = 1'b0;
      step();
      check("ur_clear", underrun, 0);
      check("ur_hold", underrun_cnt, 3);

      // Streaming: one frame first, then 40 cycles of simultaneous write/read.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_data = 32'h100 + i;
         step();
      end
      rd_req = 1'b1;
      fd_seen = 0;
      for (int j = 1; j <= 40; j++) begin
         wr_data = 32'h200 + j;
         step();
         b  = ((j - 1) / 4) % 2;
         wb = (((j - 1) / 4) + 1) % 2;
         if (frame_done) fd_seen++;
         $display("stream cycle=%0d RE=%b WE=%b Addr0=%0d Addr1=%0d rd_sel=%0b underrun=%0b", j, {RE1, RE0}, {WE1, WE0}, Addr0, Addr1, rd_sel, underrun);
         check("st_RE", {RE1, RE0}, (b == 0) ? 2'b01 : 2'b10);
         check("st_WE", {WE1, WE0}, (wb == 0) ? 2'b01 : 2'b10);
         check("st_conflict", (RE0 & WE0) | (RE1 & WE1), 0);
         check("st_rd_addr", (b == 0) ? Addr0 : Addr1, (j - 1) % 4);
         check("st_rd_sel", rd_sel, b);
         check("st_underrun", underrun, 0);
         check("st_pix_valid", pix_valid, (j >= 2) ? 1 : 0);
      end
      check("st_frames", fd_seen, 10);
      check("st_frame_cnt", frame_cnt, 2);

      // One read into the next frame, then reset on the second read.
      wr_valid = 1'b0;
      step();
      check("pre_rst_RE0", RE0, 1);
      reset = 1'b1;
      step();
      $display("reset mid-frame WE=%b RE=%b pix_valid=%0b frame_cnt=%0d", {WE1, WE0}, {RE1, RE0}, pix_valid, frame_cnt);
      check("mrst_strobes", {WE1, RE1, WE0, RE0}, 0);
      check("mrst_addr", {Addr1, Addr0}, 0);
      check("mrst_wdata", WData, 0);
      check("mrst_flags", {pix_valid, rd_sel, frame_done, underrun}, 0);
      check("mrst_counters", {frame_cnt, underrun_cnt}, 0);
      check("mrst_full", dut.full_reg, 0);
      check("mrst_wr_ready", wr_ready, 1);
      reset = 1'b0; rd_req = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
